sim_run_ctrl: RTL and testbench

Parametrised simulation run controller, replacing the fixed reset-timeout and fixed cycle-budget logic in the CPU test bench top.
- Sequences the CPU reset and counts run cycles.
- Detects end-of-test by watching the instruction fetch address: branch-to-self means halt.
- Reports a sticky PASS / FAIL / TIMEOUT verdict that the bench top uses to call $finish.
- Synthesisable RTL so it can also sit in an FPGA harness.

---
 rtl/sim_run_pkg.sv | 23 ++
 rtl/addr_stall_det.sv | 45 ++++
 rtl/sim_run_ctrl.sv | 103 ++++++++++
 tb/tb_sim_run_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sim_run_pkg.sv
// Shared types for the simulation run controller: verdict encoding and FSM states.
package sim_run_pkg;

  typedef enum logic [1:0] {
    RUNNING = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Plain encodings for bench tops that decode status in $display.
  localparam logic [1:0] STATUS_RUNNING = 2'd0;
  localparam logic [1:0] STATUS_PASS    = 2'd1;
  localparam logic [1:0] STATUS_FAIL    = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

endpackage

// File: rtl/addr_stall_det.sv
// Branch-to-self detector: counts consecutive equal fetch addresses while enabled
// and strobes halt on the comparison that would reach STALL_LIMIT.
module addr_stall_det
  import sim_run_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  halt,
  output logic [ADDR_WIDTH-1:0] prev_addr
);

  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0]         stall_cnt_q, stall_cnt_d;
  logic [ADDR_WIDTH-1:0] prev_addr_q;
  logic                  same;

  always_comb begin
    same        = (addr == prev_addr_q);
    stall_cnt_d = '0;
    halt        = 1'b0;
    if (en && same) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
      halt        = (stall_cnt_q == CW'(STALL_LIMIT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      prev_addr_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      prev_addr_q <= addr;
    end
  end

  assign prev_addr = prev_addr_q;

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: sequences CPU reset, counts run cycles and latches
// a sticky PASS/FAIL/TIMEOUT verdict from halt or cycle-budget detection.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter int unsigned           RESET_CYCLES = 5,
  parameter int unsigned           MAX_CYCLES   = 1200,
  parameter int unsigned           STALL_LIMIT  = 16,
  parameter logic [ADDR_WIDTH-1:0] PASS_ADDR    = 8'hFC,
  parameter int unsigned           CNT_WIDTH    = 32,
  parameter int unsigned           HOLD_ON_DONE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  done_pulse,
  output status_e               status,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [ADDR_WIDTH-1:0] halt_addr
);

  localparam int unsigned HW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned HOLD_LAST = (RESET_CYCLES == 0) ? 0 : RESET_CYCLES - 1;
  localparam int unsigned MAX_LAST  = (MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1;

  state_e                state_q;
  logic [HW-1:0]         hold_cnt_q;
  logic                  cpu_reset_n_q, done_q, done_pulse_q;
  status_e               status_q;
  logic [CNT_WIDTH-1:0]  cycle_count_q;
  logic [ADDR_WIDTH-1:0] halt_addr_q;

  logic                  halt;
  logic                  timeout;
  logic [ADDR_WIDTH-1:0] prev_addr;

  addr_stall_det #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == RUN),
    .addr     (imem_addr),
    .halt     (halt),
    .prev_addr(prev_addr)
  );

  assign timeout = (MAX_CYCLES != 0) && (cycle_count_q == CNT_WIDTH'(MAX_LAST));

  // On a halt prev_addr equals imem_addr, so capturing it keeps imem_addr off any output path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= HOLD;
      hold_cnt_q    <= '0;
      cpu_reset_n_q <= 1'b0;
      done_q        <= 1'b0;
      done_pulse_q  <= 1'b0;
      status_q      <= RUNNING;
      cycle_count_q <= '0;
      halt_addr_q   <= '0;
    end else begin
      done_pulse_q <= 1'b0;
      case (state_q)
        HOLD: begin
          hold_cnt_q <= hold_cnt_q + HW'(1);
          if (hold_cnt_q == HW'(HOLD_LAST)) begin
            state_q       <= RUN;
            cpu_reset_n_q <= 1'b1;
          end
        end
        RUN: begin
          if (halt || timeout) begin
            state_q       <= DONE;
            done_q        <= 1'b1;
            done_pulse_q  <= 1'b1;
            cpu_reset_n_q <= (HOLD_ON_DONE == 0);
            if (halt) begin
              halt_addr_q <= prev_addr;
              status_q    <= (prev_addr == PASS_ADDR) ? PASS : FAIL;
            end else begin
              status_q    <= TIMEOUT;
            end
          end else if (cycle_count_q != '1) begin
            cycle_count_q <= cycle_count_q + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_reset_n = cpu_reset_n_q;
  assign done        = done_q;
  assign done_pulse  = done_pulse_q;
  assign status      = status_q;
  assign cycle_count = cycle_count_q;
  assign halt_addr   = halt_addr_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: three instances cover defaults, a short
// cycle budget, and zero reset hold with a single-comparison stall limit.
module tb_sim_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [7:0] addr_a, addr_b, addr_c;

  logic        crn_a, done_a, dp_a;
  logic [1:0]  st_a;
  logic [31:0] cc_a;
  logic [7:0]  ha_a;
  logic        crn_b, done_b, dp_b;
  logic [1:0]  st_b;
  logic [31:0] cc_b;
  logic [7:0]  ha_b;
  logic        crn_c, done_c, dp_c;
  logic [1:0]  st_c;
  logic [31:0] cc_c;
  logic [7:0]  ha_c;

  int tests = 0;
  int fails = 0;

  sim_run_ctrl dut_a (
    .clk(clk), .reset(rst_a), .imem_addr(addr_a), .cpu_reset_n(crn_a), .done(done_a),
    .done_pulse(dp_a), .status(st_a), .cycle_count(cc_a), .halt_addr(ha_a)
  );

  sim_run_ctrl #(.MAX_CYCLES(100)) dut_b (
    .clk(clk), .reset(rst_b), .imem_addr(addr_b), .cpu_reset_n(crn_b), .done(done_b),
    .done_pulse(dp_b), .status(st_b), .cycle_count(cc_b), .halt_addr(ha_b)
  );

  sim_run_ctrl #(
    .RESET_CYCLES(0), .MAX_CYCLES(0), .STALL_LIMIT(1), .PASS_ADDR(8'h10), .HOLD_ON_DONE(0)
  ) dut_c (
    .clk(clk), .reset(rst_c), .imem_addr(addr_c), .cpu_reset_n(crn_c), .done(done_c),
    .done_pulse(dp_c), .status(st_c), .cycle_count(cc_c), .halt_addr(ha_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_crn"},  crn_a,  32'd0);
    check({tag, "_done"}, done_a, 32'd0);
    check({tag, "_dp"},   dp_a,   32'd0);
    check({tag, "_st"},   st_a,   32'd0);
    check({tag, "_cc"},   cc_a,   32'd0);
    check({tag, "_ha"},   ha_a,   32'd0);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    addr_a = 8'h00; addr_b = 8'h00; addr_c = 8'h00;

    // Reset sequencing on defaults: release at cycle 10, CPU out of reset 5 edges later.
    step(10);
    check_reset_a("a_rst");
    rst_a = 1'b1;
    step(4);
    check("a_hold_crn", crn_a, 32'd0);
    step(1);
    check("a_run_crn",  crn_a,  32'd1);
    check("a_run_st",   st_a,   32'd0);
    check("a_run_cc0",  cc_a,   32'd0);
    check("a_run_done", done_a, 32'd0);

    // PASS halt: 10 distinct addresses, then parked at FC.
    for (int i = 1; i <= 10; i++) begin
      addr_a = 8'(4 * i);
      step(1);
    end
    addr_a = 8'hFC;
    step(1);
    step(15);
    check("a_pass_15cmp_done", done_a, 32'd0);
    step(1);
    check("a_pass_done", done_a, 32'd1);
    check("a_pass_dp",   dp_a,   32'd1);
    check("a_pass_st",   st_a,   32'd1);
    check("a_pass_ha",   ha_a,   32'hFC);
    check("a_pass_crn",  crn_a,  32'd0);
    check("a_pass_cc",   cc_a,   32'd26);
    step(1);
    check("a_pass_dp_off", dp_a,   32'd0);
    check("a_pass_done2",  done_a, 32'd1);
    check("a_pass_cc2",    cc_a,   32'd26);
    addr_a = 8'h20;
    step(3);
    check("a_frozen_st", st_a, 32'd1);
    check("a_frozen_ha", ha_a, 32'hFC);

    // One-cycle reset pulse while in DONE.
    rst_a = 1'b0;
    addr_a = 8'h00;
    step(1);
    check_reset_a("a_rst_done");
    rst_a = 1'b1;
    step(5);
    check("a_rerun_crn", crn_a, 32'd1);

    // FAIL: 15 equal comparisons at 40 (near miss), break, then a full run at 40.
    addr_a = 8'h40;
    step(1);
    step(15);
    check("a_nearmiss_done", done_a, 32'd0);
    addr_a = 8'h44;
    step(1);
    check("a_break_done", done_a, 32'd0);
    addr_a = 8'h40;
    step(1);
    step(15);
    check("a_fail_15cmp_done", done_a, 32'd0);
    step(1);
    check("a_fail_done", done_a, 32'd1);
    check("a_fail_dp",   dp_a,   32'd1);
    check("a_fail_st",   st_a,   32'd2);
    check("a_fail_ha",   ha_a,   32'h40);
    check("a_fail_crn",  crn_a,  32'd0);
    check("a_fail_cc",   cc_a,   32'd33);

    // Timeout with a 100-cycle budget and no repeats.
    rst_b = 1'b1;
    step(5);
    check("b_run_crn", crn_b, 32'd1);
    for (int k = 1; k <= 99; k++) begin
      addr_b = 8'(k);
      step(1);
    end
    check("b_to_pre_done", done_b, 32'd0);
    check("b_to_pre_cc",   cc_b,   32'd99);
    addr_b = 8'd100;
    step(1);
    check("b_to_done", done_b, 32'd1);
    check("b_to_dp",   dp_b,   32'd1);
    check("b_to_st",   st_b,   32'd3);
    check("b_to_cc",   cc_b,   32'd99);
    check("b_to_ha",   ha_b,   32'd0);
    check("b_to_crn",  crn_b,  32'd0);
    step(1);
    check("b_to_dp_off", dp_b, 32'd0);
    check("b_to_cc2",    cc_b, 32'd99);

    // Halt on the same edge as the timeout: halt wins.
    rst_b = 1'b0;
    addr_b = 8'h00;
    step(2);
    rst_b = 1'b1;
    step(5);
    for (int k = 1; k <= 83; k++) begin
      addr_b = 8'(k);
      step(1);
    end
    addr_b = 8'hFC;
    step(16);
    check("b_sim_pre_done", done_b, 32'd0);
    check("b_sim_pre_cc",   cc_b,   32'd99);
    step(1);
    check("b_sim_done", done_b, 32'd1);
    check("b_sim_st",   st_b,   32'd1);
    check("b_sim_cc",   cc_b,   32'd99);
    check("b_sim_ha",   ha_b,   32'hFC);

    // Zero reset hold, single-comparison halt, CPU left running in DONE.
    check("c_rst_crn", crn_c, 32'd0);
    rst_c = 1'b1;
    step(1);
    check("c_run_crn", crn_c, 32'd1);
    check("c_run_st",  st_c,  32'd0);
    check("c_run_cc",  cc_c,  32'd0);
    addr_c = 8'h10;
    step(1);
    check("c_first_done", done_c, 32'd0);
    step(1);
    check("c_pass_done", done_c, 32'd1);
    check("c_pass_dp",   dp_c,   32'd1);
    check("c_pass_st",   st_c,   32'd1);
    check("c_pass_ha",   ha_c,   32'h10);
    check("c_pass_crn",  crn_c,  32'd1);
    check("c_pass_cc",   cc_c,   32'd1);
    addr_c = 8'h33;
    step(2);
    check("c_frozen_ha", ha_c, 32'h10);
    check("c_frozen_st", st_c, 32'd1);
    check("c_frozen_dp", dp_c, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
